irq_req_agent: RTL
==================

# irq_req_agent

Request-side agent for the 9-channel combinational priority interrupt encoder. Captures rising edges on nine interrupt sources into pending latches, presents masked pending requests to the encoder, and consumes the encoder's winning channel index. It then runs the CPU-side request/acknowledge/end-of-interrupt handshake, so that only one channel is in service at a time.

## Interface
Parameters:
- NCH, 9, number of interrupt channels (1..15)
- IDXW, 4, width of channel index / vector

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- src_i  in  NCH  interrupt source levels; a rising edge raises a request
- mask_i  in  NCH  1 = channel masked; its pending bit is kept but not requested
- req_o  out  NCH  request vector to encoder: pending & ~mask_i, forced to 0 while not IDLE
- win_valid_i  in  1  encoder reports a winner this cycle
- win_idx_i  in  IDXW  encoder winning channel index
- cpu_irq_o  out  1  interrupt request to CPU (registered)
- cpu_vec_o  out  IDXW  channel being requested/serviced (registered)
- cpu_ack_i  in  1  CPU accepts the current request
- cpu_eoi_i  in  1  CPU end-of-interrupt
- busy_o  out  1  state != IDLE
- err_o  out  1  one-cycle pulse: encoder winner invalid

## Operation
- Edge capture: src_q <= src_i every cycle. edge = src_i & ~src_q. pending[c] <= 1 on edge[c].
- req_o is combinational from pending, mask_i and state.
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - If win_valid_i and win_idx_i < NCH and req_o[win_idx_i] = 1: cpu_vec_o <= win_idx_i, cpu_irq_o <= 1, go REQ.
  - If win_valid_i and either win_idx_i >= NCH or req_o[win_idx_i] = 0: err_o pulses, stay IDLE.
- REQ:
  - cpu_irq_o is held.
  - On cpu_ack_i: pending[vec] <= 0, cpu_irq_o <= 0, go SERVICE.
  - Else if mask_i[vec] = 1: request withdrawn. cpu_irq_o <= 0, go IDLE, pending kept.
  - ack and mask in the same cycle: ack wins.
- SERVICE: on cpu_eoi_i go IDLE. cpu_vec_o holds its value until the next REQ entry.
- cpu_eoi_i outside SERVICE and cpu_ack_i outside REQ are ignored with no side effects.
- Simultaneous edge[vec] and ack clearing pending[vec]: the set wins, so pending stays 1 and the channel re-requests after EOI.
- Edges on any channel are captured in every state, including SERVICE.
- Reset values: src_q=0, pending=0, state=IDLE, cpu_irq_o=0, cpu_vec_o=0, err_o=0. req_o=0, busy_o=0.
- A source held high through reset registers exactly one edge at the first edge after rst falls.
- rst asserted mid-handshake: everything returns to reset values at the next edge. Lost requests are not restored.

## Timing
- src_i rises and is sampled at edge k: pending and req_o are set after edge k.
- cpu_irq_o is high after edge k+1, since the encoder is combinational in the same cycle.
- cpu_ack_i sampled at edge j: cpu_irq_o is low and pending is cleared after edge j.
- req_o is 0 from edge k+1 until the EOI edge.
- cpu_eoi_i at edge e: IDLE after e. The next winner can raise cpu_irq_o after edge e+1.
- Minimum back-to-back service: ack and eoi on consecutive edges gives 3 cycles per interrupt.
- err_o is registered: it is high for the one cycle after the offending edge.

## Test plan
- Reset, then pulse src_i[3] for 1 cycle at edge 5 -> req_o=0x008 after edge 5, cpu_irq_o=1 and cpu_vec_o=3 after edge 6. Ack at edge 8 -> irq=0, req_o=0. EOI at edge 10 -> busy_o=0.
- src_i[2] and src_i[7] edges in the same cycle; encoder model picks 2 -> vec=2 first. After EOI, vec=7 is requested 1 cycle later. Both pending bits end at 0.
- Enter REQ on channel 5, raise mask_i[5] with no ack -> irq drops next edge, state IDLE, pending[5]=1. Unmask -> re-request of vec=5.
- Same cycle as ack of channel 1, a new src_i[1] edge -> after EOI, channel 1 is requested again. Ack and mask asserted together -> goes to SERVICE.
- Encoder forced to win_valid_i=1, win_idx_i=12 -> err_o=1 for one cycle, no irq. Separately, eoi/ack pulsed in IDLE -> no state change.
- rst asserted while in SERVICE with src_i[0] held high -> all outputs at reset values after that edge. After release, pending[0]=1 one edge later.

Source files
------------

// File: rtl/irq_req_agent.sv
// Request-side agent for the priority interrupt encoder: edge-captures sources
// into pending latches, offers masked requests, and runs the CPU req/ack/eoi handshake.
module irq_req_agent #(
   parameter int NCH  = 9,
   parameter int IDXW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NCH-1:0]  src_i,
   input  logic [NCH-1:0]  mask_i,
   output logic [NCH-1:0]  req_o,
   input  logic            win_valid_i,
   input  logic [IDXW-1:0] win_idx_i,
   output logic            cpu_irq_o,
   output logic [IDXW-1:0] cpu_vec_o,
   input  logic            cpu_ack_i,
   input  logic            cpu_eoi_i,
   output logic            busy_o,
   output logic            err_o
);

   // Vectors padded to the full index range so any encoder index can be looked up safely.
   localparam int NPAD = 1 << IDXW;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_SERVICE
   } state_t;

   state_t          state_q, state_d;
   logic [NCH-1:0]  src_q, src_d;
   logic [NCH-1:0]  pend_q, pend_d;
   logic            irq_q, irq_d;
   logic [IDXW-1:0] vec_q, vec_d;
   logic            err_q, err_d;

   logic [NCH-1:0]  src_rise;
   logic [NCH-1:0]  req_w;
   logic [NCH-1:0]  pend_clr;
   logic [NPAD-1:0] req_pad;
   logic [NPAD-1:0] mask_pad;
   logic [NPAD-1:0] clr_pad;
   logic            win_ok;

   assign src_rise = src_i & ~src_q;
   assign req_w    = (state_q == ST_IDLE) ? (pend_q & ~mask_i) : '0;
   assign req_pad  = NPAD'(req_w);
   assign mask_pad = NPAD'(mask_i);
   assign win_ok   = (int'(win_idx_i) < NCH) && req_pad[win_idx_i];

   always_comb begin
      state_d = state_q;
      irq_d   = irq_q;
      vec_d   = vec_q;
      err_d   = 1'b0;
      clr_pad = '0;
      src_d   = src_i;
      case (state_q)
         ST_IDLE: begin
            if (win_valid_i) begin
               if (win_ok) begin
                  vec_d   = win_idx_i;
                  irq_d   = 1'b1;
                  state_d = ST_REQ;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_REQ: begin
            // Ack beats a simultaneous mask: the CPU already committed to this vector.
            if (cpu_ack_i) begin
               clr_pad[vec_q] = 1'b1;
               irq_d          = 1'b0;
               state_d        = ST_SERVICE;
            end else if (mask_pad[vec_q]) begin
               irq_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (cpu_eoi_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      pend_clr = clr_pad[NCH-1:0];
      // A new edge on the channel being acked wins over the clear.
      pend_d   = (pend_q & ~pend_clr) | src_rise;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         pend_q  <= '0;
         irq_q   <= 1'b0;
         vec_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         pend_q  <= pend_d;
         irq_q   <= irq_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
      end
   end

   assign req_o     = req_w;
   assign cpu_irq_o = irq_q;
   assign cpu_vec_o = vec_q;
   assign busy_o    = (state_q != ST_IDLE);
   assign err_o     = err_q;

endmodule
